// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, coordinate/colour types and the window helper
// used by the timing generator and the pixel-colour generator.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    localparam int RGB_W   = 12;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    localparam int VGA_CLK_DIV        = 4;
    localparam int VGA_H_TOTAL        = 800;
    localparam int VGA_H_SYNC         = 96;
    localparam int VGA_H_BRIGHT_START = 144;
    localparam int VGA_H_BRIGHT_END   = 784;
    localparam int VGA_V_TOTAL        = 525;
    localparam int VGA_V_SYNC         = 2;
    localparam int VGA_V_BRIGHT_START = 35;
    localparam int VGA_V_BRIGHT_END   = 515;

    localparam rgb_t BLACK = 12'h000;
    localparam rgb_t WHITE = 12'hfff;
    localparam rgb_t RED   = 12'hf00;
    localparam rgb_t GREEN = 12'h0f0;
    localparam rgb_t BLUE  = 12'h00f;

    // Half-open window test [lo, hi) on unsigned coordinates.
    function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_tick_div.sv
// Pixel-rate divider: adv is the combinational advance enable (last clk of the period),
// pix_tick is the registered pulse aligned with that same clk.
module pix_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic adv,
    output logic pix_tick
);

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign adv = 1'b1;
            always_ff @(posedge clk) begin
                pix_tick <= !reset;
            end
        end else begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

            logic [DIV_W-1:0] div_cnt_reg;
            logic [DIV_W-1:0] div_cnt_next;

            always_comb begin
                div_cnt_next = (div_cnt_reg == LAST) ? '0 : div_cnt_reg + 1'b1;
            end

            // pix_tick is decoded from the next count so it lines up with div_cnt == LAST.
            always_ff @(posedge clk) begin
                if (reset) begin
                    div_cnt_reg <= '0;
                    pix_tick    <= 1'b0;
                end else begin
                    div_cnt_reg <= div_cnt_next;
                    pix_tick    <= (div_cnt_next == LAST);
                end
            end

            assign adv = (div_cnt_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, syncs and bright all registered and aligned.
// Optional frame_start/frame_count ports are enabled by defining VGA_FRAME_STROBE_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV        = VGA_CLK_DIV,
    parameter int H_TOTAL        = VGA_H_TOTAL,
    parameter int H_SYNC         = VGA_H_SYNC,
    parameter int H_BRIGHT_START = VGA_H_BRIGHT_START,
    parameter int H_BRIGHT_END   = VGA_H_BRIGHT_END,
    parameter int V_TOTAL        = VGA_V_TOTAL,
    parameter int V_SYNC         = VGA_V_SYNC,
    parameter int V_BRIGHT_START = VGA_V_BRIGHT_START,
    parameter int V_BRIGHT_END   = VGA_V_BRIGHT_END
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] hCount,
    output logic [COORD_W-1:0] vCount,
    output logic               bright,
    output logic               hSync,
    output logic               vSync,
`ifdef VGA_FRAME_STROBE_EN
    output logic               frame_start,
    output logic [7:0]         frame_count,
`endif
    output logic               pix_tick
);

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t H_SW   = coord_t'(H_SYNC);
    localparam coord_t V_SW   = coord_t'(V_SYNC);
    localparam coord_t H_BS   = coord_t'(H_BRIGHT_START);
    localparam coord_t H_BE   = coord_t'(H_BRIGHT_END);
    localparam coord_t V_BS   = coord_t'(V_BRIGHT_START);
    localparam coord_t V_BE   = coord_t'(V_BRIGHT_END);

    logic   adv;
    logic   h_wrap;
    logic   v_wrap;
    coord_t h_next;
    coord_t v_next;

    pix_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .adv     (adv),
        .pix_tick(pix_tick)
    );

    always_comb begin
        h_wrap = (hCount == H_LAST);
        v_wrap = (vCount == V_LAST);
        h_next = hCount;
        v_next = vCount;
        if (adv) begin
            h_next = h_wrap ? '0 : hCount + 1'b1;
            if (h_wrap) begin
                v_next = v_wrap ? '0 : vCount + 1'b1;
            end
        end
    end

    // Decodes come from next-state counters so they land in the same cycle as the counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            hCount <= '0;
            vCount <= '0;
            hSync  <= 1'b0;
            vSync  <= 1'b0;
            bright <= 1'b0;
        end else begin
            hCount <= h_next;
            vCount <= v_next;
            hSync  <= (h_next >= H_SW);
            vSync  <= (v_next >= V_SW);
            bright <= in_window(h_next, H_BS, H_BE) && in_window(v_next, V_BS, V_BE);
        end
    end

`ifdef VGA_FRAME_STROBE_EN
    logic frame_wrap;
    assign frame_wrap = adv && h_wrap && v_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance (line timing) and a shrunken instance
// (frame, bright window, strobe, reset), each checked every cycle against a position model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       br;
        logic       hs;
        logic       vs;
        logic       tk;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] h_a, v_a, h_b, v_b;
    logic br_a, hs_a, vs_a, tk_a, br_b, hs_b, vs_b, tk_b;
    logic fs_a, fs_b;
    logic [7:0] fc_a, fc_b;

    int checks = 0;
    int errors = 0;
    int t_a = 0, t_b = 0;
    bit va = 0, vb = 0;
    int fs_cnt = 0;

    vga_timing_gen u_a (
        .clk(clk), .reset(rst_a), .hCount(h_a), .vCount(v_a), .bright(br_a),
        .hSync(hs_a), .vSync(vs_a),
`ifdef VGA_FRAME_STROBE_EN
        .frame_start(fs_a), .frame_count(fc_a),
`endif
        .pix_tick(tk_a)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_TOTAL(20), .H_SYNC(3), .H_BRIGHT_START(5), .H_BRIGHT_END(17),
        .V_TOTAL(10), .V_SYNC(2), .V_BRIGHT_START(3), .V_BRIGHT_END(8)
    ) u_b (
        .clk(clk), .reset(rst_b), .hCount(h_b), .vCount(v_b), .bright(br_b),
        .hSync(hs_b), .vSync(vs_b),
`ifdef VGA_FRAME_STROBE_EN
        .frame_start(fs_b), .frame_count(fc_b),
`endif
        .pix_tick(tk_b)
    );

`ifndef VGA_FRAME_STROBE_EN
    assign fs_a = 1'b0;
    assign fs_b = 1'b0;
    assign fc_a = 8'd0;
    assign fc_b = 8'd0;
`endif

    // Position model: t clks after reset means floor(t/div) pixel advances.
    function automatic exp_t model(input int t, input int div, input int ht, input int hsw,
                                   input int hbs, input int hbe, input int vt, input int vsw,
                                   input int vbs, input int vbe);
        exp_t e;
        int p, h, v;
        p = t / div;
        h = p % ht;
        v = (p / ht) % vt;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = (h >= hsw);
        e.vs = (v >= vsw);
        e.br = (h >= hbs) && (h < hbe) && (v >= vbs) && (v < vbe);
        e.tk = ((t % div) == div - 1);
`ifdef VGA_FRAME_STROBE_EN
        e.fs = ((t % div) == 0) && (p > 0) && ((p % (ht * vt)) == 0);
        e.fc = 8'((p / (ht * vt)) % 256);
`else
        e.fs = 1'b0;
        e.fc = 8'd0;
`endif
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst_a) begin t_a <= 0; va <= 1'b1; end else if (va) t_a <= t_a + 1;
        if (rst_b) begin t_b <= 0; vb <= 1'b1; end else if (vb) t_b <= t_b + 1;
    end

    always @(negedge clk) begin
        if (rst_b) fs_cnt = 0;
        else if (fs_b) fs_cnt++;
    end

    // Every-cycle compare of both instances against the model.
    always @(negedge clk) begin
        exp_t e, g;
        if (va) begin
            e = model(t_a, 4, 800, 96, 144, 784, 525, 2, 35, 515);
            g = '{h: h_a, v: v_a, br: br_a, hs: hs_a, vs: vs_a, tk: tk_a, fs: fs_a, fc: fc_a};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cyc_a t=%0d got h=%0d v=%0d br=%b hs=%b vs=%b tk=%b fs=%b fc=%0d exp h=%0d v=%0d br=%b hs=%b vs=%b tk=%b fs=%b fc=%0d",
                         t_a, g.h, g.v, g.br, g.hs, g.vs, g.tk, g.fs, g.fc, e.h, e.v, e.br, e.hs, e.vs, e.tk, e.fs, e.fc);
            end
        end
        if (vb) begin
            e = model(t_b, 4, 20, 3, 5, 17, 10, 2, 3, 8);
            g = '{h: h_b, v: v_b, br: br_b, hs: hs_b, vs: vs_b, tk: tk_b, fs: fs_b, fc: fc_b};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cyc_b t=%0d got h=%0d v=%0d br=%b hs=%b vs=%b tk=%b fs=%b fc=%0d exp h=%0d v=%0d br=%b hs=%b vs=%b tk=%b fs=%b fc=%0d",
                         t_b, g.h, g.v, g.br, g.hs, g.vs, g.tk, g.fs, g.fc, e.h, e.v, e.br, e.hs, e.vs, e.tk, e.fs, e.fc);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic at_a(input int target);
        int n = 0;
        while (t_a != target && n < 10000) begin @(negedge clk); n++; end
        if (t_a != target) chk("wait_a", t_a, target);
    endtask

    task automatic at_b(input int target);
        int n = 0;
        while (t_b != target && n < 10000) begin @(negedge clk); n++; end
        if (t_b != target) chk("wait_b", t_b, target);
    endtask

    initial begin
        int n_vs, n_br, n_hs, n_tk;
        repeat (3) @(negedge clk);
        // Cycle 0 after reset: origin inside both sync pulses.
        chk("rst_h", int'(h_a), 0);
        chk("rst_v", int'(v_a), 0);
        chk("rst_hsync", int'(hs_a), 0);
        chk("rst_vsync", int'(vs_a), 0);
        chk("rst_bright", int'(br_a), 0);
        chk("rst_tick", int'(tk_a), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        at_b(3);  chk("tick_clk3", int'(tk_a), 1); chk("h_clk3", int'(h_a), 0);
        at_b(4);  chk("h_clk4", int'(h_a), 1);     chk("tick_clk4", int'(tk_a), 0);
        at_b(7);  chk("tick_clk7", int'(tk_a), 1);
        at_b(8);  chk("h_clk8", int'(h_a), 2);
        at_b(11); chk("tick_clk11", int'(tk_a), 1);

        // Small instance bright window corners.
        at_b(256); chk("b_br_4_3", int'(br_b), 0);
        at_b(260); chk("b_br_5_3", int'(br_b), 1);
        at_b(624); chk("b_br_16_7", int'(br_b), 1);
        at_b(628); chk("b_br_17_7", int'(br_b), 0);
        at_b(660); chk("b_br_5_8", int'(br_b), 0);
        at_b(799); chk("b_last_h", int'(h_b), 19); chk("b_last_v", int'(v_b), 9);
        at_b(800); chk("b_wrap_h", int'(h_b), 0);  chk("b_wrap_v", int'(v_b), 0);

        n_vs = 0; n_br = 0;
        repeat (800) begin
            if (!vs_b) n_vs++;
            if (br_b) n_br++;
            @(negedge clk);
        end
        chk("b_vsync_low_clks", n_vs, 160);
        chk("b_bright_clks", n_br, 240);

`ifdef VGA_FRAME_STROBE_EN
        at_b(2401);
        chk("b_frame_pulses", fs_cnt, 3);
        chk("b_frame_count", int'(fc_b), 3);
`endif

        // Mid-frame reset at (12,6) of the fourth frame, one clk wide.
        at_b(2928);
        chk("b_pre_rst_h", int'(h_b), 12);
        chk("b_pre_rst_v", int'(v_b), 6);
        rst_b = 1'b1;
        @(negedge clk);
        chk("b_mrst_h", int'(h_b), 0);
        chk("b_mrst_v", int'(v_b), 0);
        chk("b_mrst_syncs", int'({hs_b, vs_b}), 0);
        chk("b_mrst_bright", int'(br_b), 0);
        rst_b = 1'b0;
        at_b(3); chk("b_mrst_h3", int'(h_b), 0);
        at_b(4); chk("b_mrst_h4", int'(h_b), 1);

        // Long reset holds everything at the origin.
        rst_b = 1'b1;
        repeat (10) @(negedge clk);
        chk("b_hold_h", int'(h_b), 0);
        chk("b_hold_tick", int'(tk_b), 0);
        rst_b = 1'b0;
        at_b(4); chk("b_hold_resume_h", int'(h_b), 1);

        // Full-size line timing.
        at_a(3199); chk("a_h_799", int'(h_a), 799); chk("a_v_0", int'(v_a), 0);
        at_a(3200); chk("a_h_wrap", int'(h_a), 0);  chk("a_v_1", int'(v_a), 1);
        n_hs = 0; n_tk = 0;
        repeat (3200) begin
            if (!hs_a) n_hs++;
            if (tk_a) n_tk++;
            @(negedge clk);
        end
        chk("a_hsync_low_clks", n_hs, 384);
        chk("a_ticks_per_line", n_tk, 800);
        chk("a_line2_h", int'(h_a), 0);
        chk("a_line2_v", int'(v_a), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA 640x480@60 raster timing from the 100 MHz board clock.
- Drives hSync/vSync to the connector.
- Drives hCount, vCount and bright to the pixel-colour generator, which returns 12-bit rgb for each pixel.
- All outputs are registered and mutually aligned, so the colour logic can decode raw counter values directly.

Parameters:
- CLK_DIV, 4: board clocks per pixel; must be >= 1; 1 = advance every clock.
- H_TOTAL, 800: pixels per line, counted 0..H_TOTAL-1.
- H_SYNC, 96: hSync asserted (low) while hCount < H_SYNC.
- H_BRIGHT_START, 144: first visible hCount.
- H_BRIGHT_END, 784: first non-visible hCount after the active region (exclusive).
- V_TOTAL, 525: lines per frame, counted 0..V_TOTAL-1.
- V_SYNC, 2: vSync asserted (low) while vCount < V_SYNC.
- V_BRIGHT_START, 35: first visible vCount.
- V_BRIGHT_END, 515: exclusive end of visible lines.

Ports:
- clk  in  1  board clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- hCount  out  10  raw horizontal position, 0..799, including sync and porches.
- vCount  out  10  raw vertical position, 0..524.
- bright  out  1  high when both counters are inside their visible windows.
- hSync  out  1  active-low horizontal sync.
- vSync  out  1  active-low vertical sync.
- pix_tick  out  1  one-clk pulse on the cycle the counters advance.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high; all state updates on posedge clk only.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick is registered, high for exactly the one clk in which div_cnt == CLK_DIV-1.
  - Counters advance on the edge at the end of that cycle.
- Counters (update only when div_cnt == CLK_DIV-1):
  - hCount = (hCount == H_TOTAL-1) ? 0 : hCount+1.
  - vCount changes only when hCount wraps: (vCount == V_TOTAL-1) ? 0 : vCount+1.
  - Both wrap to 0 on the same edge at the frame end (799,524 -> 0,0).
  - hCount never reaches H_TOTAL; vCount never reaches V_TOTAL.
- Decodes:
  - hSync = !(hCount < H_SYNC).
  - vSync = !(vCount < V_SYNC).
  - bright = (H_BRIGHT_START <= hCount < H_BRIGHT_END) && (V_BRIGHT_START <= vCount < V_BRIGHT_END).
- Alignment and latency:
  - Decodes are computed from the next-state counter values and registered.
  - hSync, vSync and bright therefore always correspond to the hCount/vCount visible in the same cycle.
  - Zero-cycle skew between counters and decodes.
- Reset, including mid-frame:
  - Next edge forces div_cnt=0, hCount=0, vCount=0, pix_tick=0, bright=0.
  - hSync=0 and vSync=0, since position 0,0 is inside both sync pulses.
  - Counting restarts from a full divider period: the first advance occurs CLK_DIV clks after reset deasserts.
  - Reset held for many cycles keeps all outputs at these values.
- Comparisons use 10-bit unsigned arithmetic, with no signed or negative intermediates.
- No external handshake. The consumer samples counters combinationally every clk, and values are stable for CLK_DIV clks.

Optional Feature:
- Macro: VGA_FRAME_STROBE_EN.
- When defined, adds two ports:
  - frame_start (out 1): high for exactly one clk, the cycle in which the counters first hold 0,0 after a wrap. It is not asserted after reset.
  - frame_count (out 8): increments on each frame_start, wraps 255 -> 0, resets to 0.
- Intended for animation and game-tick timing.
- When undefined, neither port exists and no extra flops are inferred.

Decomposition:
- Package vga_timing_pkg holds the 640x480 constants (totals, sync widths, bright windows), the 10-bit coordinate width, and the 12-bit RGB width and colour constants (e.g. BLACK) shared with the colour generator.
- One natural sub-module, pix_tick_div: parameterised CLK_DIV counter producing the advance enable and pix_tick.

Test Plan:
- Reset release, CLK_DIV=4:
  - hCount=0 for the first 4 clks, hCount=1 at clk 4, hCount=2 at clk 8.
  - pix_tick pulses at clks 3, 7, 11.
- Line timing: hSync low for exactly 384 clks per line; line period 3200 clks; vCount increments exactly when hCount goes 799 -> 0.
- Frame timing: vSync low for exactly 6400 clks; frame period 1,680,000 clks; 799,524 -> 0,0 on a single edge.
- Bright window:
  - bright first high at (144,35) and last high at (783,514).
  - Low at (784,35), (143,35) and (144,515).
  - Exactly 307,200 bright pixel-periods per frame.
- Mid-frame reset: assert at (400,200) for 1 clk -> next cycle all counters 0, hSync=vSync=0, bright=0; counting resumes after 4 clks.
- With VGA_FRAME_STROBE_EN: run 3 frames -> frame_start pulses 3 times, each 1 clk wide at 0,0, and frame_count reads 3.
